// File: rtl/ipc_pkg.sv
// Shared types and constants for the inter-process channel.
// A record is one (process_id, value) pair written by a device.
package ipc_pkg;

  localparam int IPC_PID_W = 16;
  localparam int IPC_VAL_W = 32;

  localparam logic [7:0] PROM_ID    = 8'h02;
  localparam logic [7:0] CONSDEV_ID = 8'h03;

  typedef struct packed {
    logic [IPC_PID_W-1:0] pid;
    logic [IPC_VAL_W-1:0] value;
  } ipc_rec_t;

  localparam int IPC_REC_W = $bits(ipc_rec_t);

endpackage

// File: rtl/ipc_sync_fifo.sv
// Single-clock FIFO with an explicit occupancy counter.
// When full, a push is accepted only if a pop happens in the same cycle.
module ipc_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 48,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [LVL_W-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LVL_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // DEPTH is a power of two, so pointer increments wrap on their own.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = empty ? '0 : mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/ipc_out_channel.sv
// Turns every change of the device's (process_id, value) pair into a queued
// record, drained by a host consumer; overflow is flagged and counted.
module ipc_out_channel
  import ipc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IPC_PID_W-1:0]     process_id,
  input  logic [IPC_VAL_W-1:0]     value,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [IPC_PID_W-1:0]     rd_pid,
  output logic [IPC_VAL_W-1:0]     rd_value,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_count
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  ipc_rec_t          pair_in, shadow_q, shadow_d, head;
  logic              pair_known, push_req, pop, drop;
  logic              fifo_full, fifo_empty;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  assign pair_in.pid   = process_id;
  assign pair_in.value = value;

  // Any unknown input bit is treated as "no change" so X never enters the queue.
  assign pair_known = !$isunknown(pair_in);
  assign push_req   = pair_known && (pair_in != shadow_q);

  // Handshake: a record transfers at a posedge where rd_valid && rd_ready;
  // rd_pid/rd_value hold while rd_valid is high and rd_ready is low.
  assign rd_valid = !fifo_empty;
  assign pop      = rd_valid && rd_ready;
  assign drop     = push_req && fifo_full && !pop;

  always_comb begin
    shadow_d   = shadow_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push_req) shadow_d = pair_in;
    if (drop) begin
      overflow_d = 1'b1;
      if (drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shadow_q   <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      shadow_q   <= shadow_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  ipc_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (IPC_REC_W),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .pop   (pop),
    .din   (pair_in),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  assign rd_pid     = head.pid;
  assign rd_value   = head.value;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_ipc_out_channel.sv
// Directed bench for ipc_out_channel: inputs change and outputs are checked
// 1 time unit after each posedge, against hand-derived values.
module tb_ipc_out_channel;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] process_id;
  logic [31:0] value;
  logic        rd_valid;
  logic        rd_ready;
  logic [15:0] rd_pid;
  logic [31:0] rd_value;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  ipc_out_channel #(.DEPTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .process_id (process_id),
    .value      (value),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_pid     (rd_pid),
    .rd_value   (rd_value),
    .level      (level),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    // ---- 1: reset, then idle at the reset pair
    reset = 1'b1; process_id = 16'h0; value = 32'h0; rd_ready = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    check("rst_pid", 32'(rd_pid), 32'd0);
    check("rst_value", rd_value, 32'd0);
    for (int i = 0; i < 5; i++) step();
    check("idle_valid", 32'(rd_valid), 32'd0);
    check("idle_level", 32'(level), 32'd0);
    check("idle_ovf", 32'(overflow), 32'd0);

    // ---- 2: single write, one-cycle latency, holding adds nothing
    process_id = 16'h0003; value = 32'h0000_0041;
    step();
    check("w1_valid", 32'(rd_valid), 32'd1);
    check("w1_pid", 32'(rd_pid), 32'h0003);
    check("w1_value", rd_value, 32'h41);
    check("w1_level", 32'(level), 32'd1);
    step(); step(); step();
    check("hold_level", 32'(level), 32'd1);
    check("hold_value", rd_value, 32'h41);

    // ---- 3: two more writes, then drain in order
    exp_q.delete();
    exp_q.push_back(32'h41);
    value = 32'h42; step(); exp_q.push_back(32'h42);
    value = 32'h43; step(); exp_q.push_back(32'h43);
    check("w3_level", 32'(level), 32'd3);
    rd_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_v = exp_q.pop_front();
      check("w3_valid", 32'(rd_valid), 32'd1);
      check("w3_order", rd_value, exp_v);
      step();
    end
    check("w3_empty", 32'(rd_valid), 32'd0);
    check("w3_level0", 32'(level), 32'd0);
    check("w3_nullpop", rd_value, 32'd0);
    rd_ready = 1'b0;

    // ---- 4: 18 distinct values into a 16-deep FIFO
    exp_q.delete();
    for (int i = 0; i < 18; i++) begin
      value = 32'h100 + 32'(i);
      if (i < 16) exp_q.push_back(value);
      step();
    end
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_drop", 32'(drop_count), 32'd2);
    check("ovf_pid", 32'(rd_pid), 32'h0003);

    // ---- 5: full, push and pop in the same cycle
    exp_v = exp_q.pop_front();
    check("fp_head", rd_value, exp_v);
    value = 32'h200; rd_ready = 1'b1;
    exp_q.push_back(32'h200);
    step();
    check("fp_level", 32'(level), 32'd16);
    check("fp_drop", 32'(drop_count), 32'd2);
    for (int i = 0; i < 16; i++) begin
      exp_v = exp_q.pop_front();
      check("fp_valid", 32'(rd_valid), 32'd1);
      check("fp_order", rd_value, exp_v);
      step();
    end
    check("fp_empty", 32'(rd_valid), 32'd0);
    check("fp_sticky", 32'(overflow), 32'd1);
    check("fp_drop2", 32'(drop_count), 32'd2);
    rd_ready = 1'b0;

    // ---- 6: reset mid-stream with 5 records queued
    for (int i = 0; i < 5; i++) begin
      value = 32'h300 + 32'(i);
      step();
    end
    check("mr_level5", 32'(level), 32'd5);
    reset = 1'b1;
    step();
    check("mr_level", 32'(level), 32'd0);
    check("mr_valid", 32'(rd_valid), 32'd0);
    check("mr_ovf", 32'(overflow), 32'd0);
    check("mr_drop", 32'(drop_count), 32'd0);
    reset = 1'b0; process_id = 16'h0002; value = 32'h0;
    step();
    check("mr_rec_level", 32'(level), 32'd1);
    check("mr_rec_pid", 32'(rd_pid), 32'h0002);
    check("mr_rec_value", rd_value, 32'h0);
    step();
    check("mr_hold_level", 32'(level), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
